// File: rtl/ram_wr_arbiter.sv
// ram_wr_arbiter: two-requester write-port arbiter for a single-port RAM, with a
// built-in zero-fill sequence.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   init_req            request to zero-fill the whole RAM
//   init_busy           zero-fill in progress
//   req0/addr0/data0    requester 0 write valid, address, data
//   gnt0                requester 0 owns the write port
//   req1/addr1/data1    requester 1 write valid, address, data
//   gnt1                requester 1 owns the write port
//   wr_en/wr_addr/wr_data  registered RAM write strobe, address, data
//
// A grant lasts up to maxb beats or until the owner drops its request. Every
// release is followed by one grant-free idle cycle. Contention is resolved by a
// round-robin pointer that always favours the requester that did not own last.
// Every output is a flop or a decode of the state register.
module ram_wr_arbiter #(
  parameter int unsigned n    = 16,
  parameter int unsigned w    = 4,
  parameter int unsigned maxb = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init_req,
  output logic         init_busy,
  input  logic         req0,
  input  logic [w-1:0] addr0,
  input  logic [7:0]   data0,
  output logic         gnt0,
  input  logic         req1,
  input  logic [w-1:0] addr1,
  input  logic [7:0]   data1,
  output logic         gnt1,
  output logic         wr_en,
  output logic [w-1:0] wr_addr,
  output logic [7:0]   wr_data
);

  localparam int unsigned BcW = (maxb > 1) ? $clog2(maxb) : 1;

  localparam logic [BcW-1:0] BcLast   = BcW'(maxb - 1);
  localparam logic [BcW-1:0] BcOne    = BcW'(1);
  localparam logic [w-1:0]   FillLast = w'(n - 1);
  localparam logic [w-1:0]   FillOne  = w'(1);

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1,
    StInit
  } state_e;

  state_e         state_q;
  logic           rr_q;      // 0: requester 0 wins a tie, 1: requester 1 wins
  logic [BcW-1:0] bc_q;      // beats already taken in the current grant
  logic [w-1:0]   fill_q;    // address being issued by the zero-fill
  logic           wr_en_q;
  logic [w-1:0]   wr_addr_q;
  logic [7:0]     wr_data_q;

  // Request/payload of whichever requester currently owns the port.
  logic         own_req;
  logic [w-1:0] own_addr;
  logic [7:0]   own_data;

  always_comb begin
    own_req  = 1'b0;
    own_addr = addr0;
    own_data = data0;
    if (state_q == StOwn0) begin
      own_req = req0;
    end else if (state_q == StOwn1) begin
      own_req  = req1;
      own_addr = addr1;
      own_data = data1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_q      <= 1'b0;
      bc_q      <= '0;
      fill_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (init_req) begin
            // The first fill write is issued in the first INIT cycle.
            state_q   <= StInit;
            fill_q    <= '0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
          end else if (req0 && (!req1 || !rr_q)) begin
            state_q <= StOwn0;
          end else if (req1) begin
            state_q <= StOwn1;
          end
        end

        StOwn0, StOwn1: begin
          if (own_req) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= own_addr;
            wr_data_q <= own_data;
          end
          if (!own_req || (bc_q == BcLast)) begin
            // Release: hand priority to the other requester.
            state_q <= StIdle;
            bc_q    <= '0;
            rr_q    <= (state_q == StOwn0);
          end else begin
            bc_q <= bc_q + BcOne;
          end
        end

        StInit: begin
          if (fill_q == FillLast) begin
            // Counter parks at the last address; it is cleared on the next entry.
            state_q <= StIdle;
          end else begin
            fill_q    <= fill_q + FillOne;
            wr_en_q   <= 1'b1;
            wr_addr_q <= fill_q + FillOne;
            wr_data_q <= 8'h00;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt0      = (state_q == StOwn0);
  assign gnt1      = (state_q == StOwn1);
  assign init_busy = (state_q == StInit);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// tb_ram_wr_arbiter: directed scenarios plus random traffic for ram_wr_arbiter,
// checked cycle by cycle against a transaction-level reference model.
module tb_ram_wr_arbiter;

  localparam int N    = 16;
  localparam int W    = 4;
  localparam int MAXB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init_req = 1'b0;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] addr0 = '0;
  logic [W-1:0] addr1 = '0;
  logic [7:0]   data0 = '0;
  logic [7:0]   data1 = '0;
  logic         init_busy, gnt0, gnt1, wr_en;
  logic [W-1:0] wr_addr;
  logic [7:0]   wr_data;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] wlog[$];  // observed writes {addr, data}

  // Reference model: owner 0 = nobody, 1 = requester 0, 2 = requester 1, 3 = zero-fill.
  int owner, beats, fill, m_addr, m_data;
  bit rr, m_we;

  ram_wr_arbiter #(.n(N), .w(W), .maxb(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .init_busy (init_busy),
    .req0      (req0),
    .addr0     (addr0),
    .data0     (data0),
    .gnt0      (gnt0),
    .req1      (req1),
    .addr1     (addr1),
    .data1     (data1),
    .gnt1      (gnt1),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs_vec();
    return {gnt0, gnt1, init_busy, wr_en, wr_addr, wr_data};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [W-1:0] a;
    logic [7:0]   d;
    a = W'(m_addr);
    d = 8'(m_data);
    return {owner == 1, owner == 2, owner == 3, m_we, a, d};
  endfunction

  task automatic model_reset();
    owner = 0; beats = 0; fill = 0; rr = 0; m_we = 0; m_addr = 0; m_data = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit r;
    m_we = 0;
    if (owner == 0) begin
      if (init_req) begin
        owner = 3; fill = 0; m_we = 1; m_addr = 0; m_data = 0;
      end else if (req0 && req1) begin
        owner = rr ? 2 : 1;
      end else if (req0) begin
        owner = 1;
      end else if (req1) begin
        owner = 2;
      end
    end else if (owner == 3) begin
      if (fill == N - 1) begin
        owner = 0;
      end else begin
        fill = fill + 1; m_we = 1; m_addr = fill; m_data = 0;
      end
    end else begin
      r = (owner == 1) ? req0 : req1;
      if (r) begin
        m_we   = 1;
        m_addr = (owner == 1) ? int'(addr0) : int'(addr1);
        m_data = (owner == 1) ? int'(data0) : int'(data1);
        beats  = beats + 1;
      end
      if (!r || beats == MAXB) begin
        rr = (owner == 1);
        owner = 0;
        beats = 0;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    if (wr_en) wlog.push_back({wr_addr, wr_data});
  endtask

  task automatic settle(input int cycles);
    req0 = 0; req1 = 0; init_req = 0;
    for (int i = 0; i < cycles; i++) cycle();
  endtask

  task automatic test_reset();
    req0 = 1; req1 = 1; init_req = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_vec() !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want %h", obs_vec(), 16'h0);
    end
    req0 = 0; req1 = 0; init_req = 0;
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      cycle();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single_burst();
    bit beat;
    settle(3);
    wlog.delete();
    addr0 = 4'd3; data0 = 8'h3C ^ 8'd3; req0 = 1;
    for (int i = 0; i < 8; i++) begin
      beat = (owner == 1);
      cycle();
      if (beat) begin
        addr0 = addr0 + W'(1);
        data0 = 8'h3C ^ {4'h0, addr0};
      end
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL burst cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    req0 = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL burst_tail cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (wlog.size() !== 6) begin
      miscompares++;
      $display("FAIL burst_count: got %0d want 6", wlog.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        logic [W-1:0] a;
        logic [7:0] d;
        a = W'(3 + k);
        d = 8'h3C ^ {4'h0, a};
        vectors++;
        if (wlog[k] !== {a, d}) begin
          miscompares++;
          $display("FAIL burst_write %0d: got %h want %h", k, wlog[k], {a, d});
        end
      end
    end
  endtask

  task automatic test_contention();
    logic g0, g1;
    @(negedge clk);
    #1 rst_n = 0;
    req0 = 1; req1 = 1; init_req = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int c = 1; c <= 25; c++) begin
      addr0 = W'($urandom); data0 = 8'($urandom);
      addr1 = W'($urandom); data1 = 8'($urandom);
      cycle();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL contention cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      // Fixed rotation: 4 cycles OWN0, idle, 4 cycles OWN1, idle.
      g0 = ((c - 1) % 10) < 4;
      g1 = ((c - 1) % 10) >= 5 && ((c - 1) % 10) <= 8;
      vectors++;
      if ({gnt0, gnt1} !== {g0, g1}) begin
        miscompares++;
        $display("FAIL contention_pattern cyc %0d: got %b want %b", c, {gnt0, gnt1}, {g0, g1});
      end
    end
  endtask

  task automatic test_early_release();
    bit beat;
    int nb;
    settle(3);
    wlog.delete();
    nb = 0;
    addr1 = 4'd9; data1 = 8'hA5; req1 = 1;
    for (int i = 0; i < 6; i++) begin
      beat = (owner == 2) && req1;
      cycle();
      if (beat) begin
        nb++;
        if (nb == 1) begin
          addr1 = 4'd10; data1 = 8'h5A;
        end else begin
          req1 = 0;
        end
      end
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL early cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (wlog.size() !== 2 || wlog[0] !== {4'd9, 8'hA5} || wlog[1] !== {4'd10, 8'h5A}) begin
      miscompares++;
      $display("FAIL early_writes: got %0d writes want 2 (9:a5, 10:5a)", wlog.size());
    end
    // Pointer now favours requester 0.
    req0 = 1; req1 = 1;
    cycle();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin
      miscompares++;
      $display("FAIL early_rr: got %b want 10", {gnt0, gnt1});
    end
  endtask

  task automatic test_init();
    int busy_cnt, first_g0;
    settle(4);
    busy_cnt = 0; first_g0 = -1;
    req0 = 1; addr0 = 4'hF; data0 = 8'hEE;
    for (int i = 0; i < 20; i++) begin
      init_req = (i == 0);
      cycle();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL init cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (init_busy) begin
        vectors++;
        if (!wr_en || wr_addr !== W'(busy_cnt) || wr_data !== 8'h00 || gnt0) begin
          miscompares++;
          $display("FAIL init_fill %0d: got en%b a%h d%h g%b want en1 a%h d00 g0",
                   busy_cnt, wr_en, wr_addr, wr_data, gnt0, W'(busy_cnt));
        end
        busy_cnt++;
      end
      if (gnt0 && first_g0 < 0) first_g0 = i;
    end
    vectors++;
    if (busy_cnt !== N || first_g0 !== N + 1) begin
      miscompares++;
      $display("FAIL init_span: got busy %0d first_gnt %0d want %0d %0d",
               busy_cnt, first_g0, N, N + 1);
    end
  endtask

  task automatic test_init_during_grant();
    int g_cnt, last_g, first_b;
    settle(4);
    g_cnt = 0; last_g = -1; first_b = -1;
    req0 = 1; addr0 = 4'h2; data0 = 8'h11;
    cycle();
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL igrant_start: got %h want %h", obs_vec(), exp_vec());
    end
    if (gnt0) g_cnt++;
    init_req = 1;
    for (int i = 0; i < 24; i++) begin
      addr0 = W'($urandom); data0 = 8'($urandom);
      cycle();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL igrant cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (init_busy) begin
        init_req = 0;
        if (first_b < 0) first_b = i;
      end
      if (gnt0 && first_b < 0) begin
        g_cnt++;
        last_g = i;
      end
    end
    vectors++;
    if (g_cnt !== MAXB || first_b !== last_g + 2) begin
      miscompares++;
      $display("FAIL igrant_order: got gnt %0d first_busy %0d last_gnt %0d want gnt %0d gap 2",
               g_cnt, first_b, last_g, MAXB);
    end
  endtask

  task automatic test_reset_mid_init();
    bit hit;
    settle(3);
    req0 = 1;
    cycle();
    cycle();
    req0 = 0;
    cycle();  // released from OWN0, pointer now favours requester 1
    settle(2);
    init_req = 1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle();
      init_req = 0;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rinit cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (init_busy && wr_addr == W'(7)) hit = 1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL rinit_reach: got no fill at addr 7 want one");
    end
    #2 rst_n = 0;
    #1;
    vectors++;
    if (obs_vec() !== 16'h0) begin
      miscompares++;
      $display("FAIL rinit_async: got %h want %h", obs_vec(), 16'h0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cycle();
    vectors++;
    if (obs_vec() !== 16'h0) begin
      miscompares++;
      $display("FAIL rinit_after: got %h want %h", obs_vec(), 16'h0);
    end
    req0 = 1; req1 = 1;
    cycle();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin
      miscompares++;
      $display("FAIL rinit_rr: got %b want 10", {gnt0, gnt1});
    end
  endtask

  task automatic test_random();
    settle(3);
    for (int i = 0; i < 500; i++) begin
      req0 = ($urandom % 3) != 0;
      req1 = ($urandom % 3) != 0;
      init_req = ($urandom % 30) == 0;
      addr0 = W'($urandom); data0 = 8'($urandom);
      addr1 = W'($urandom); data1 = 8'($urandom);
      cycle();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      vectors++;
      if (gnt0 && gnt1) begin
        miscompares++;
        $display("FAIL random_mutex cyc %0d: got both grants want at most one", i);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_burst();
    test_contention();
    test_early_release();
    test_init();
    test_init_during_grant();
    test_reset_mid_init();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
